// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler that shares one external NBitAddSub datapath between NUM_REQ
// requesters. One request is accepted per operation. Its operands are registered and
// driven to the adder. The adder result is captured one cycle later together with the
// carry, the signed-overflow flag and the requester ID. That capture is returned on a
// single valid/ready response port.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (ready is one-hot or zero)
//   req_a_i, req_b_i      packed operands, requester i at [i*BITWIDTH +: BITWIDTH]
//   req_sub_i             per-requester op select, 1 = a-b, 0 = a+b
//   dp_a_o, dp_b_o, dp_sub_o   operands to the shared adder
//   dp_sum_i, dp_cout_i   combinational adder result
//   rsp_valid_o/ready_i   response handshake
//   rsp_id_o, rsp_sum_o, rsp_cout_o, rsp_ovf_o   registered response fields
module addsub_rr_sched #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NUM_REQ  = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_b_i,
  input  logic [NUM_REQ-1:0]           req_sub_i,
  output logic [BITWIDTH-1:0]          dp_a_o,
  output logic [BITWIDTH-1:0]          dp_b_o,
  output logic                         dp_sub_o,
  input  logic [BITWIDTH-1:0]          dp_sum_i,
  input  logic                         dp_cout_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [BITWIDTH-1:0]          rsp_sum_o,
  output logic                         rsp_cout_o,
  output logic                         rsp_ovf_o
);

  localparam int unsigned Msb = BITWIDTH - 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BITWIDTH-1:0] a_q, b_q;
  logic                sub_q;
  logic [ID_W-1:0]     id_q;
  logic [BITWIDTH-1:0] rsp_sum_q;
  logic                rsp_cout_q, rsp_ovf_q;
  logic [ID_W-1:0]     rsp_id_q;

  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [BITWIDTH-1:0] sel_a, sel_b;
  logic                sel_sub;
  logic                accept;
  logic                ovf;

  // Rotating priority: first valid index at or above rr_ptr, else the lowest valid index.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_vld && req_valid_i[i] && (ID_W'(i) >= rr_ptr_q)) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_vld && req_valid_i[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a   = req_a_i[i*BITWIDTH +: BITWIDTH];
        sel_b   = req_b_i[i*BITWIDTH +: BITWIDTH];
        sel_sub = req_sub_i[i];
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_vld && !rst_i;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Effective b MSB is inverted for subtraction (a + ~b + 1).
  assign ovf = (a_q[Msb] == (b_q[Msb] ^ sub_q)) && (dp_sum_i[Msb] != a_q[Msb]);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = (state_q == StResp);
    if ((state_q == StIdle) && !rst_i) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        req_ready_o[i] = grant_vld && (ID_W'(i) == grant_idx);
      end
    end
  end

  // Operand, pointer and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        sub_q <= sel_sub;
        id_q  <= grant_idx;
      end
      if (state_q == StExec) begin
        rsp_sum_q  <= dp_sum_i;
        rsp_cout_q <= dp_cout_i;
        rsp_ovf_q  <= ovf;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign dp_a_o     = a_q;
  assign dp_b_o     = b_q;
  assign dp_sub_o   = sub_q;
  assign rsp_sum_o  = rsp_sum_q;
  assign rsp_cout_o = rsp_cout_q;
  assign rsp_ovf_o  = rsp_ovf_q;
  assign rsp_id_o   = rsp_id_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Bench for addsub_rr_sched: directed cases followed by random traffic. Each grant
// pushes the expected response into a scoreboard, and a negedge monitor compares it.
module tb_addsub_rr_sched;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [N-1:0]   sub_v = '0;
  logic [W-1:0]   a_v[N];
  logic [W-1:0]   b_v[N];
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   dp_a, dp_b, dp_sum;
  logic           dp_sub, dp_cout;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout, rsp_ovf;

  int checks = 0;
  int errors = 0;

  rsp_t sb[$];
  rsp_t rsp_log[$];
  int   grant_log[$];
  int   hs_cnt[N] = '{default: 0};
  int   seen[N] = '{default: 0};

  int          phase = 0;
  int          mptr = 0;
  logic [W-1:0] ma, mb;
  logic        ms;
  bit          found;
  int          g;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
    end
  end

  // Stand-in for the shared NBitAddSub instance.
  assign {dp_cout, dp_sum} = dp_sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1)
                                    : ({1'b0, dp_a} + {1'b0, dp_b});

  addsub_rr_sched #(.BITWIDTH(W), .NUM_REQ(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(valid),
    .req_ready_o(req_ready),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_sub_i  (sub_v),
    .dp_a_o     (dp_a),
    .dp_b_o     (dp_b),
    .dp_sub_o   (dp_sub),
    .dp_sum_i   (dp_sum),
    .dp_cout_i  (dp_cout),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o   (rsp_id),
    .rsp_sum_o  (rsp_sum),
    .rsp_cout_o (rsp_cout),
    .rsp_ovf_o  (rsp_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic rsp_t ref_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s);
    rsp_t r;
    int ua, ub, sa, sbv, u, sg;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (s) begin
      u      = ua - ub;
      sg     = sa - sbv;
      r.cout = (ua >= ub);
    end else begin
      u      = ua + ub;
      sg     = sa + sbv;
      r.cout = (u >= (1 << W));
    end
    u     = ((u % (1 << W)) + (1 << W)) % (1 << W);
    r.sum = W'(u);
    r.ovf = (sg > (1 << (W - 1)) - 1) || (sg < -(1 << (W - 1)));
    r.id  = IW'(id);
    return r;
  endfunction

  // Monitor: phase 0 = idle expected, 1 = exec, 2 = response pending.
  always @(negedge clk) begin
    rsp_t act;
    if (rst) begin
      chk("ready_during_rst", 32'(req_ready), 32'd0);
      phase = 0;
      mptr  = 0;
      sb.delete();
    end else if (phase == 1) begin
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("dp_a", 32'(dp_a), 32'(ma));
      chk("dp_b", 32'(dp_b), 32'(mb));
      chk("dp_sub", 32'(dp_sub), 32'(ms));
      phase = 2;
    end else if (phase == 2) begin
      chk("resp_ready_zero", 32'(req_ready), 32'd0);
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      chk("rsp_sum", 32'(rsp_sum), 32'(sb[0].sum));
      chk("rsp_cout", 32'(rsp_cout), 32'(sb[0].cout));
      chk("rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
      if (rsp_ready) begin
        act.id   = rsp_id;
        act.sum  = rsp_sum;
        act.cout = rsp_cout;
        act.ovf  = rsp_ovf;
        rsp_log.push_back(act);
        void'(sb.pop_front());
        phase = 0;
      end
    end else begin
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && valid[(mptr + k) % N]) begin
          found = 1'b1;
          g     = (mptr + k) % N;
        end
      end
      chk("grant", 32'(req_ready), found ? (32'd1 << g) : 32'd0);
      if (found) begin
        sb.push_back(ref_op(g, a_v[g], b_v[g], sub_v[g]));
        ma    = a_v[g];
        mb    = b_v[g];
        ms    = sub_v[g];
        mptr  = (g + 1) % N;
        phase = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (valid[i] && req_ready[i]) begin
        hs_cnt[i]++;
        grant_log.push_back(i);
      end
    end
  end

  task automatic rand_ops(input int i);
    a_v[i]   = W'($urandom);
    b_v[i]   = W'($urandom);
    sub_v[i] = 1'($urandom);
  endtask

  task automatic wait_hs(input int i);
    int c;
    c = 0;
    while (hs_cnt[i] == seen[i] && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("hs_req%0d", i), 32'(hs_cnt[i] != seen[i]), 32'd1);
    seen[i] = hs_cnt[i];
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    a_v[i]   = a;
    b_v[i]   = b;
    sub_v[i] = s;
    valid[i] = 1'b1;
    wait_hs(i);
    valid[i] = 1'b0;
  endtask

  // Wait for n handshakes among the currently valid requesters.
  task automatic run_hs(input int n, input bit refill);
    int cnt, c;
    cnt = 0;
    c   = 0;
    while (cnt < n && c < 400) begin
      @(posedge clk); #1;
      c++;
      for (int i = 0; i < N; i++) begin
        if (hs_cnt[i] != seen[i]) begin
          seen[i] = hs_cnt[i];
          cnt++;
          if (refill) rand_ops(i);
          else valid[i] = 1'b0;
        end
      end
    end
    chk("hs_count", 32'(cnt), 32'(n));
  endtask

  logic [W-1:0] e_sum[4]  = '{8'h08, 8'hFE, 8'h80, 8'h7F};
  logic         e_cout[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic         e_ovf[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int base, c;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    // Reset with every requester asserting valid.
    rst   = 1'b1;
    valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
    chk("rst_dp_a", 32'(dp_a), 32'd0);
    chk("rst_dp_b", 32'(dp_b), 32'd0);
    chk("rst_dp_sub", 32'(dp_sub), 32'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    valid = '0;

    // Directed add, subtract and overflow cases from requester 0.
    base = rsp_log.size();
    issue(0, 8'h05, 8'h03, 1'b0);
    issue(0, 8'h03, 8'h05, 1'b1);
    issue(0, 8'h7F, 8'h01, 1'b0);
    issue(0, 8'h80, 8'h01, 1'b1);
    c = 0;
    while (rsp_log.size() < base + 4 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("directed_rsp_count", 32'(rsp_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < rsp_log.size()) begin
        chk($sformatf("dir%0d_id", k), 32'(rsp_log[base+k].id), 32'd0);
        chk($sformatf("dir%0d_sum", k), 32'(rsp_log[base+k].sum), 32'(e_sum[k]));
        chk($sformatf("dir%0d_cout", k), 32'(rsp_log[base+k].cout), 32'(e_cout[k]));
        chk($sformatf("dir%0d_ovf", k), 32'(rsp_log[base+k].ovf), 32'(e_ovf[k]));
      end
    end

    // Round-robin: all four requesters hold valid for eight ops, starting from ptr 0.
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    base = grant_log.size();
    for (int i = 0; i < N; i++) rand_ops(i);
    valid = '1;
    run_hs(8, 1'b1);
    valid = '0;
    for (int k = 0; k < 8; k++) begin
      if (base + k < grant_log.size())
        chk($sformatf("rr_order%0d", k), 32'(grant_log[base+k]), 32'(k % 4));
    end

    // Backpressure: response held five cycles while requester 2 waits.
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    issue(1, W'($urandom), W'($urandom), 1'($urandom));
    rand_ops(2);
    valid[2] = 1'b1;
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(hs_cnt[2] - seen[2]), 32'd0);
    rsp_ready = 1'b1;
    wait_hs(2);
    valid[2] = 1'b0;

    // Reset during EXEC: no response, pointer back to 0.
    repeat (4) @(posedge clk);
    #1;
    issue(1, W'($urandom), W'($urandom), 1'($urandom));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    base = rsp_log.size();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_no_rsp", 32'(rsp_log.size() - base), 32'd0);
    base = grant_log.size();
    rand_ops(0);
    rand_ops(3);
    valid[0] = 1'b1;
    valid[3] = 1'b1;
    run_hs(2, 1'b0);
    if (base + 1 < grant_log.size()) begin
      chk("post_rst_first", 32'(grant_log[base]), 32'd0);
      chk("post_rst_second", 32'(grant_log[base+1]), 32'd3);
    end

    // Random traffic with random backpressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs_cnt[i] != seen[i]) begin
          seen[i]  = hs_cnt[i];
          valid[i] = 1'b0;
        end
        if (!valid[i] && $urandom_range(0, 2) == 0) begin
          rand_ops(i);
          valid[i] = 1'b1;
        end
      end
    end

    // Drain.
    valid     = '0;
    rsp_ready = 1'b1;
    c = 0;
    while ((phase != 0 || sb.size() != 0) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
